// File: rtl/alu_pkg.sv
// Shared types for the pipelined ALU: opcode encoding, flag bundle and carry-update decode.
// Shift support follows the ALU_PIPE_SHIFT_EN macro.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SHL = 3'b101,
    OP_SHR = 3'b110,
    OP_ADC = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic cout;
    logic zero;
    logic neg;
    logic ovf;
  } alu_flags_t;

  // Shifts only own the carry register when the shifter exists.
  function automatic logic updates_carry(alu_op_e op);
    case (op)
      OP_ADD, OP_SUB, OP_ADC: return 1'b1;
`ifdef ALU_PIPE_SHIFT_EN
      OP_SHL, OP_SHR:         return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: result, flags and carry-write enable from one operand set.
// The barrel shifter is present only when ALU_PIPE_SHIFT_EN is defined.
module alu_pipe_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          sel_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] result_o,
  output alu_flags_t       flags_o,
  output logic             carry_we_o
);

  logic [WIDTH:0] add_b;
  logic           add_cin;
  logic [WIDTH:0] sum;
  logic [WIDTH-1:0] res;
  logic           res_cout;
  logic           res_ovf;

  // SUB reuses the adder as a + ~b + 1, so sum[WIDTH] reads as "no borrow".
  always_comb begin
    add_b   = {1'b0, b_i};
    add_cin = 1'b0;
    if (sel_i == OP_SUB) begin
      add_b   = {1'b0, ~b_i};
      add_cin = 1'b1;
    end else if (sel_i == OP_ADC) begin
      add_cin = carry_i;
    end
  end

  assign sum = {1'b0, a_i} + add_b + {{WIDTH{1'b0}}, add_cin};

`ifdef ALU_PIPE_SHIFT_EN
  logic [SHW-1:0] shamt;
  logic [WIDTH:0] shl_w;
  logic [WIDTH:0] shr_w;

  // One guard bit on each side catches the last bit shifted out; it is 0 for a zero shift.
  assign shamt = b_i[SHW-1:0];
  assign shl_w = {1'b0, a_i} << shamt;
  assign shr_w = {a_i, 1'b0} >> shamt;
`else
  logic unused_shamt;
  assign unused_shamt = ^b_i[SHW-1:0];
`endif

  always_comb begin
    res      = '0;
    res_cout = 1'b0;
    res_ovf  = 1'b0;
    case (sel_i)
      OP_ADD, OP_ADC: begin
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_ovf  = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        res      = sum[WIDTH-1:0];
        res_cout = sum[WIDTH];
        res_ovf  = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (res[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_AND: res = a_i & b_i;
      OP_OR:  res = a_i | b_i;
      OP_XOR: res = a_i ^ b_i;
`ifdef ALU_PIPE_SHIFT_EN
      OP_SHL: begin
        res      = shl_w[WIDTH-1:0];
        res_cout = shl_w[WIDTH];
      end
      OP_SHR: begin
        res      = shr_w[WIDTH:1];
        res_cout = shr_w[0];
      end
`endif
      default: begin
        res      = '0;
        res_cout = 1'b0;
      end
    endcase
  end

  assign result_o     = res;
  assign flags_o.cout = res_cout;
  assign flags_o.zero = ~|res;
  assign flags_o.neg  = res[WIDTH-1];
  assign flags_o.ovf  = res_ovf;
  assign carry_we_o   = updates_carry(sel_i);

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline: stage 1 holds operands, stage 2 holds result and flags.
// SHL/SHR are live only when ALU_PIPE_SHIFT_EN is defined; otherwise they yield zero.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  // Handshake: a beat moves on a side only in a cycle where valid && ready are both high
  // at the rising edge; an offered beat stays held until taken, and a stalled output
  // (out_valid && !out_ready) keeps result and flags frozen. in_ready is combinational.
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  alu_op_e          op_q, op_d;

  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  alu_flags_t       flags_q, flags_d;
  logic             carry_q, carry_d;

  logic             adv1, adv2;
  logic [WIDTH-1:0] core_result;
  alu_flags_t       core_flags;
  logic             core_carry_we;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  alu_pipe_core #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_core (
    .a_i        (a_q),
    .b_i        (b_q),
    .sel_i      (op_q),
    .carry_i    (carry_q),
    .result_o   (core_result),
    .flags_o    (core_flags),
    .carry_we_o (core_carry_we)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        a_d  = a;
        b_d  = b;
        op_d = alu_op_e'(sel);
      end
    end
  end

  // The carry register updates in issue order at the 1->2 move, so an ADC right
  // behind a carry producer sees its carry without any forwarding.
  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;
    carry_d    = carry_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = core_result;
        flags_d  = core_flags;
        if (core_carry_we) begin
          carry_d = core_flags.cout;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_ADD;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      carry_q    <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      carry_q    <= carry_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign result    = result_q;
  assign cout      = flags_q.cout;
  assign zero      = flags_q.zero;
  assign neg       = flags_q.neg;
  assign ovf       = flags_q.ovf;

endmodule
